mult_control: RTL and testbench
===============================

MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; iteration count equals WIDTH.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin one multiplication; sampled only in IDLE.
REQ-006 prod_lsb  input  1  bit 0 of product register (current multiplier bit).
REQ-007 load_ctrl  output  1  load multiplicand register and product register (multiplier into low half, high half cleared).
REQ-008 add_ctrl  output  1  write ALU sum (product high half + multiplicand) plus carry into product high half.
REQ-009 shift_ctrl  output  1  shift product register (with carry) right by one.
REQ-010 ready  output  1  controller idle and accepting start.
REQ-011 done  output  1  single-cycle pulse; product register holds final result.
REQ-012 iter_count  output  CNT_W  number of completed shift iterations.

Function
REQ-013 FSM states IDLE, LOAD, CHECK, ADD, SHIFT, DONE; all outputs Moore-decoded from state register and counter, no input-to-output combinational paths.
REQ-014 IDLE: ready=1, strobes 0; start=1 -> LOAD; start=0 -> IDLE.
REQ-015 LOAD: load_ctrl=1 for exactly one cycle; counter cleared to 0; -> CHECK.
REQ-016 CHECK: no strobes; prod_lsb=1 -> ADD; prod_lsb=0 -> SHIFT.
REQ-017 ADD: add_ctrl=1 for exactly one cycle; -> SHIFT.
REQ-018 SHIFT: shift_ctrl=1 for exactly one cycle; counter increments; counter==WIDTH-1 before increment -> DONE, else -> CHECK.
REQ-019 DONE: done=1 for one cycle, iter_count==WIDTH; -> IDLE.
REQ-020 At most one of load_ctrl, add_ctrl, shift_ctrl SHALL be high in any cycle.
REQ-021 Latency: start sampled at edge t0 -> done high in cycle t0+2+2*WIDTH+k, k = number of 1 bits in multiplier (WIDTH=32: 66..98).
REQ-022 start asserted outside IDLE (including DONE) SHALL be ignored, not queued.
REQ-023 prod_lsb SHALL be ignored outside CHECK.
REQ-024 start held high continuously SHALL produce back-to-back operations, each beginning with LOAD on the cycle after IDLE.
REQ-025 iter_count SHALL hold its value in IDLE until next LOAD.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE and counter 0 regardless of state, including mid-operation.
REQ-027 After reset: ready=1, done=0, load_ctrl=0, add_ctrl=0, shift_ctrl=0, iter_count=0.
REQ-028 reset SHALL take priority over start in the same cycle.

Structure
REQ-029 Shared package mult_pkg SHALL hold the state enumeration, WIDTH and CNT_W defaults, for reuse by datapath and bench.
REQ-030 Iteration counter SHALL be sub-module mult_iter_counter (clear, increment, terminal-count flag).

Verification
REQ-031 reset, then start=1 one cycle, multiplier=0 -> load_ctrl once, 32 shift_ctrl, 0 add_ctrl, done at t0+66, iter_count=32.
REQ-032 multiplier=0xFFFFFFFF -> 32 add_ctrl each immediately before a shift_ctrl, done at t0+98.
REQ-033 multiplier=0x00000005 -> add_ctrl only in iterations 0 and 2, done at t0+68; with datapath, 7*5 yields product 35.
REQ-034 start pulsed during CHECK/ADD/SHIFT and in DONE -> no extra LOAD, operation completes unchanged, ready returns after DONE.
REQ-035 reset asserted during iteration 10 -> next cycle IDLE, all strobes 0, iter_count=0, ready=1; subsequent start runs full 32 iterations.
REQ-036 start held high 3 operations -> three done pulses, each followed by exactly one IDLE cycle then LOAD; strobe one-hot assertion never fails.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding and
// default operand/counter widths, reused by the controller, datapath and bench.
package mult_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 6;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StAdd,
        StShift,
        StDone
    } state_t;

endpackage

// File: rtl/mult_control_if.sv
// Handshake and strobe bundle between the multiplier controller (slave side) and
// whoever drives start and observes the datapath strobes (master side).
interface mult_control_if import mult_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             prod_lsb;
    logic             load_ctrl;
    logic             add_ctrl;
    logic             shift_ctrl;
    logic             ready;
    logic             done;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start,
        output prod_lsb,
        input  load_ctrl,
        input  add_ctrl,
        input  shift_ctrl,
        input  ready,
        input  done,
        input  iter_count
    );

    modport slave (
        input  start,
        input  prod_lsb,
        output load_ctrl,
        output add_ctrl,
        output shift_ctrl,
        output ready,
        output done,
        output iter_count
    );

endinterface

// File: rtl/mult_iter_counter.sv
// Iteration counter for the shift-add controller: synchronous clear, increment,
// and a terminal flag raised while the count sits at WIDTH-1.
module mult_iter_counter import mult_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_incr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// Moore FSM sequencing a shift-add multiplier: load, then WIDTH rounds of
// check/(add)/shift, then a one-cycle done pulse.
module mult_control import mult_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    mult_control_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_clear;
    logic             w_incr;
    logic             w_terminal;
    logic [CNT_W-1:0] w_count;

    mult_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_incr     (w_incr),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_incr       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_clear      = 1'b1;
                w_state_next = StCheck;
            end
            StCheck: begin
                w_state_next = bus.prod_lsb ? StAdd : StShift;
            end
            StAdd: begin
                w_state_next = StShift;
            end
            StShift: begin
                // Terminal is judged on the pre-increment count, so DONE sees WIDTH.
                w_incr       = 1'b1;
                w_state_next = w_terminal ? StDone : StCheck;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.ready      = (r_state == StIdle);
    assign bus.load_ctrl  = (r_state == StLoad);
    assign bus.add_ctrl   = (r_state == StAdd);
    assign bus.shift_ctrl = (r_state == StShift);
    assign bus.done       = (r_state == StDone);
    assign bus.iter_count = w_count;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: cycle-level schedule model plus a shift-add datapath
// model driven by the DUT strobes, with directed cases and random traffic.
module tb_mult_control;
    import mult_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef struct packed {
        logic             chk;
        logic             rdy;
        logic             ld;
        logic             ad;
        logic             sh;
        logic             dn;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mult_control_if #(.CNT_W(CNT_W)) mif ();

    mult_control #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int          tot = 0;
    int          bad = 0;
    bit          cmp_en = 1'b0;
    exp_t        q[$];
    logic [5:0]  held = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [63:0] exp_prod = '0;
    logic [64:0] p = '0;
    logic [31:0] mc = '0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tot++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic exp_t mk(input logic ck, input logic rd, input logic ld, input logic ad,
                                input logic sh, input logic dn, input logic [CNT_W-1:0] cnt);
        exp_t e;
        e.chk = ck; e.rdy = rd; e.ld = ld; e.ad = ad; e.sh = sh; e.dn = dn; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t cur_exp();
        if (q.size() > 0) return q[0];
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, held);
    endfunction

    // Expected cycle-by-cycle outputs of one whole operation for multiplier m.
    function automatic void build(input logic [31:0] m);
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, held));
        for (int i = 0; i < int'(WIDTH); i++) begin
            q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(i)));
            if (m[i]) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CNT_W'(i)));
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(i)));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(WIDTH)));
    endfunction

    // One clock: drive inputs at negedge, advance models at posedge, return at next negedge.
    task automatic cycle(input bit st, input bit rs);
        exp_t        h;
        exp_t        e;
        logic [64:0] pn;
        logic [31:0] mcn;
        h = cur_exp();
        mif.start    = st;
        reset        = rs;
        mif.prod_lsb = h.chk ? p[0] : 1'($urandom);
        pn  = p;
        mcn = mc;
        if (mif.load_ctrl) begin
            pn  = {33'b0, op_b};
            mcn = op_a;
        end else if (mif.add_ctrl) begin
            pn[64:32] = {1'b0, p[63:32]} + {1'b0, mc};
        end else if (mif.shift_ctrl) begin
            pn = p >> 1;
        end
        @(posedge clk);
        p  = pn;
        mc = mcn;
        if (rs) begin
            q.delete();
            held = '0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dn) held = e.cnt;
        end else if (st) begin
            build(op_b);
            exp_prod = {32'b0, op_a} * {32'b0, op_b};
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = cur_exp();
            chk("outputs", {mif.ready, mif.load_ctrl, mif.add_ctrl, mif.shift_ctrl, mif.done,
                            mif.iter_count},
                {e.rdy, e.ld, e.ad, e.sh, e.dn, e.cnt});
            chk("strobe_onehot", 64'($onehot0({mif.load_ctrl, mif.add_ctrl, mif.shift_ctrl})), 1);
            if (e.dn) chk("product", p[63:0], exp_prod);
        end
    end

    // Single operation from IDLE; checks latency, strobe counts and product against literals.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit spur,
                          input int exp_lat, input int exp_adds, input logic [63:0] exp_p);
        int n;
        int adds;
        int shifts;
        int loads;
        op_a = a;
        op_b = b;
        adds = 0; shifts = 0; loads = 0;
        cycle(1'b1, 1'b0);
        n = 1;
        while (!mif.done && n < 200) begin
            adds   += int'(mif.add_ctrl);
            shifts += int'(mif.shift_ctrl);
            loads  += int'(mif.load_ctrl);
            cycle(spur && (n % 5 == 2), 1'b0);
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("add_count", 64'(adds), 64'(exp_adds));
        chk("shift_count", 64'(shifts), 64'(WIDTH));
        chk("load_count", 64'(loads), 1);
        chk("done_iter_count", 64'(mif.iter_count), 64'(WIDTH));
        chk("done_product", p[63:0], exp_p);
        cycle(spur, 1'b0);
        chk("idle_after_done", {mif.ready, mif.load_ctrl}, 2'b10);
        chk("idle_holds_count", 64'(mif.iter_count), 64'(WIDTH));
        cycle(1'b0, 1'b0);
        chk("no_queued_start", {mif.ready, mif.load_ctrl}, 2'b10);
    endtask

    initial begin
        int n;
        int dones;
        int last;
        mif.start    = 1'b0;
        mif.prod_lsb = 1'b0;
        reset        = 1'b1;
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cmp_en = 1'b1;
        chk("reset_state", {mif.ready, mif.done, mif.load_ctrl, mif.add_ctrl, mif.shift_ctrl,
                            mif.iter_count}, {5'b10000, 6'd0});

        run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 66, 0, 64'h0);
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 98, 32, 64'hFFFF_FFFF);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b0, 68, 2, 64'd35);
        run_op(32'h0000_0003, 32'h0000_0101, 1'b1, 68, 2, 64'h303);

        // Abort during iteration 10 (CHECK of round 10 is cycle 22 for a zero multiplier).
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0;
        cycle(1'b1, 1'b0);
        n = 1;
        while (n < 22) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        chk("mid_iter_count", 64'(mif.iter_count), 10);
        cycle(1'b0, 1'b1);
        chk("after_abort", {mif.ready, mif.done, mif.load_ctrl, mif.add_ctrl, mif.shift_ctrl,
                            mif.iter_count}, {5'b10000, 6'd0});
        run_op(32'h0000_0002, 32'h8000_0001, 1'b0, 68, 2, 64'h1_0000_0002);

        // start held high: three operations back to back, 69 cycles apart.
        op_a  = 32'd9;
        op_b  = 32'd3;
        n     = 0;
        dones = 0;
        last  = 0;
        while (dones < 3 && n < 400) begin
            cycle(1'b1, 1'b0);
            n++;
            if (mif.done) begin
                dones++;
                if (dones == 1) chk("b2b_first_done", 64'(n), 68);
                else chk("b2b_gap", 64'(n - last), 69);
                last = n;
            end
        end
        chk("b2b_done_count", 64'(dones), 3);
        cycle(1'b0, 1'b0);

        for (int c = 0; c < 6000; c++) begin
            bit st;
            bit rs;
            rs = ($urandom_range(0, 499) == 0);
            if (q.size() == 0) begin
                st = ($urandom_range(0, 2) == 0);
                if (st) begin
                    op_a = $urandom;
                    case ($urandom_range(0, 3))
                        0: op_b = $urandom;
                        1: op_b = $urandom & $urandom;
                        2: op_b = 32'hFFFF_FFFF ^ (32'd1 << $urandom_range(0, 31));
                        default: op_b = 32'($urandom_range(0, 15));
                    endcase
                end
            end else begin
                st = ($urandom_range(0, 7) == 0);
            end
            cycle(st, rs);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
